// File: rtl/hbm_delay_release_sched_pkg.sv
// Shared types and constants for the HBM delay-release scheduler and its
// delay FIFOs: FIFO entry layout, timer width, FIFO count and scheduler states.
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 64
`endif

package hbm_delay_release_sched_pkg;

  localparam int DELAY_FIFO_NUM = 2;
  localparam int TIMERw         = 10;
  localparam int MAX_RD_DELAY   = 64;
  localparam int NOC_DW         = `NOC_DATA_WIDTH;

  // Field order sets the packed layout: {head, tail, exp_time, dat} from MSB down.
  typedef struct packed {
    logic              head;
    logic              tail;
    logic [TIMERw-1:0] exp_time;
    logic [NOC_DW-1:0] dat;
  } fifo_dat_t;

  localparam int FIFO_DW = $bits(fifo_dat_t);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } sched_state_t;

endpackage

// File: rtl/hbm_rr_arb.sv
// Parametric round-robin arbiter: the first requester at or after i_ptr
// (wrapping modulo N) receives a one-hot grant.
module hbm_rr_arb #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt
);

  logic [N-1:0] w_gnt;

  always_comb begin
    int  v_idx;
    logic v_found;
    w_gnt   = '0;
    v_idx   = 0;
    v_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      v_idx = int'(i_ptr) + k;
      if (v_idx >= N) v_idx = v_idx - N;
      if (!v_found && i_req[v_idx]) begin
        w_gnt[v_idx] = 1'b1;
        v_found      = 1'b1;
      end
    end
  end

  assign o_gnt = w_gnt;

endmodule

// File: rtl/hbm_delay_release_sched.sv
// Release scheduler: free-running emulation timer, expiry-gated round-robin over
// delay FIFO heads, atomic packet drain, one-entry output register. Define
// HBM_DELAY_STATS_EN to add packet / late-cycle saturating counters.
module hbm_delay_release_sched
  import hbm_delay_release_sched_pkg::*;
#(
  parameter int NUM_FIFO = DELAY_FIFO_NUM,
  parameter int TW       = TIMERw,
  parameter int DW       = NOC_DW
) (
  input  logic                            clk,
  input  logic                            rst,
  output logic [TW-1:0]                   timer_o,
  input  logic [NUM_FIFO-1:0]             fifo_val_i,
  input  logic [NUM_FIFO*(2+TW+DW)-1:0]   fifo_dat_i,
  output logic [NUM_FIFO-1:0]             fifo_pop_o,
  output logic [DW-1:0]                   noc_dat_o,
  output logic                            noc_val_o,
  input  logic                            noc_rdy_i
`ifdef HBM_DELAY_STATS_EN
  ,
  output logic [31:0]                     stat_pkts_o,
  output logic [31:0]                     stat_late_o
`endif
);

  localparam int EW = 2 + TW + DW;
  localparam int PW = (NUM_FIFO > 1) ? $clog2(NUM_FIFO) : 1;

  logic [TW-1:0]       r_timer;
  sched_state_t        r_state, w_state_next;
  logic [PW-1:0]       r_lock, w_lock_next;
  logic [PW-1:0]       r_rr, w_rr_next;
  logic                r_val;
  logic [DW-1:0]       r_dat;

  logic [NUM_FIFO-1:0] w_head, w_tail, w_req, w_gnt, w_pop;
  logic [TW-1:0]       w_age [NUM_FIFO];
  logic [DW-1:0]       w_dat [NUM_FIFO];
  logic [PW-1:0]       w_win;
  logic                w_ld, w_load, w_sel_tail;
  logic [DW-1:0]       w_load_dat;

  for (genvar gi = 0; gi < NUM_FIFO; gi++) begin : g_fifo
    logic [EW-1:0] w_ent;
    assign w_ent      = fifo_dat_i[gi*EW +: EW];
    assign w_head[gi] = w_ent[EW-1];
    assign w_tail[gi] = w_ent[EW-2];
    assign w_dat[gi]  = w_ent[DW-1:0];
    // Deadline reached when the modular age has not gone negative.
    assign w_age[gi]  = r_timer - w_ent[DW +: TW];
    assign w_req[gi]  = fifo_val_i[gi] & w_head[gi] & ~w_age[gi][TW-1];
  end

  hbm_rr_arb #(.N(NUM_FIFO), .PW(PW)) u_arb (
    .i_req (w_req),
    .i_ptr (r_rr),
    .o_gnt (w_gnt)
  );

  always_comb begin
    w_win = '0;
    for (int i = 0; i < NUM_FIFO; i++) begin
      if (w_gnt[i]) w_win = PW'(i);
    end
  end

  assign w_ld       = !r_val || noc_rdy_i;
  assign w_sel_tail = (r_state == IDLE) ? w_tail[w_win] : w_tail[r_lock];

  always_comb begin
    w_state_next = r_state;
    w_lock_next  = r_lock;
    w_rr_next    = r_rr;
    w_pop        = '0;
    w_load       = 1'b0;
    w_load_dat   = w_dat[r_lock];
    if (!rst && w_ld) begin
      case (r_state)
        IDLE: begin
          if (|w_gnt) begin
            w_pop      = w_gnt;
            w_load     = 1'b1;
            w_load_dat = w_dat[w_win];
            w_rr_next  = (w_win == PW'(NUM_FIFO - 1)) ? '0 : w_win + PW'(1);
            if (!w_sel_tail) begin
              w_state_next = LOCKED;
              w_lock_next  = w_win;
            end
          end
        end
        LOCKED: begin
          // Body/tail flits are never expiry-gated; an empty locked FIFO just bubbles.
          if (fifo_val_i[r_lock]) begin
            w_pop[r_lock] = 1'b1;
            w_load        = 1'b1;
            if (w_sel_tail) w_state_next = IDLE;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer <= '0;
      r_state <= IDLE;
      r_lock  <= '0;
      r_rr    <= '0;
      r_val   <= 1'b0;
      r_dat   <= '0;
    end else begin
      r_timer <= r_timer + TW'(1);
      r_state <= w_state_next;
      r_lock  <= w_lock_next;
      r_rr    <= w_rr_next;
      if (w_load) begin
        r_val <= 1'b1;
        r_dat <= w_load_dat;
      end else if (noc_rdy_i) begin
        r_val <= 1'b0;
      end
    end
  end

  assign timer_o    = r_timer;
  assign fifo_pop_o = w_pop;
  assign noc_dat_o  = r_dat;
  assign noc_val_o  = r_val;

`ifdef HBM_DELAY_STATS_EN
  logic [31:0] r_stat_pkts, r_stat_late;
  logic        w_late;

  assign w_late = |(w_req & ~w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_pkts <= '0;
      r_stat_late <= '0;
    end else begin
      if (w_load && w_sel_tail && (r_stat_pkts != '1)) r_stat_pkts <= r_stat_pkts + 32'd1;
      if (w_late && (r_stat_late != '1)) r_stat_late <= r_stat_late + 32'd1;
    end
  end

  assign stat_pkts_o = r_stat_pkts;
  assign stat_late_o = r_stat_late;
`endif

  a_idle_head_only: assert property (@(posedge clk) disable iff (rst)
    (r_state == IDLE) |-> ((fifo_val_i & ~w_head) == '0));

  a_locked_no_head: assert property (@(posedge clk) disable iff (rst)
    ((r_state == LOCKED) && fifo_val_i[r_lock]) |-> !w_head[r_lock]);

endmodule
